// File: rtl/instruction_fetch_pkg.sv
// Shared types for the fetch responder: instruction/PC widths, fetch FSM encoding and the NOP word.
// Parity helper is only used when IMEM_PARITY_EN is defined.
package instruction_fetch_pkg;

    localparam int program_counter_length = 4;
    localparam int INSTR_WIDTH            = 32;

    typedef logic [INSTR_WIDTH-1:0]            instruction_t;
    typedef logic [program_counter_length-1:0] pc_reg_t;
    typedef pc_reg_t                           imem_addr_t;

    typedef logic [2:0] fetch_state_t;
    localparam fetch_state_t IDLE   = 3'd0;
    localparam fetch_state_t LOADED = 3'd1;
    localparam fetch_state_t PRIME  = 3'd2;
    localparam fetch_state_t RUN    = 3'd3;
    localparam fetch_state_t FAULT  = 3'd4;

    localparam instruction_t NOP = '0;

    // Even parity: the stored bit makes the total count of ones even.
    function automatic logic even_parity(input instruction_t word);
        return ^word;
    endfunction

endpackage

// File: rtl/instruction_fetch_imem_sdp_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port, no reset on contents.
module imem_sdp_ram #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [WIDTH-1:0]  rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch responder: owns instruction memory, loads programs from the host and serves fetches to control.
// Optional build macro IMEM_PARITY_EN adds per-word parity, a FAULT state and the parity_err port.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter int           IMEM_DEPTH = 2**program_counter_length,
    parameter instruction_t NOP_INSTR  = NOP
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              load_valid,
    output logic                              load_ready,
    input  instruction_t                      load_data,
    input  logic                              load_last,
    input  logic                              start,
    input  logic                              stop,
    input  logic                              clear,
    input  logic [program_counter_length-1:0] next_program_counter,
    output instruction_t                      instruction,
    output logic                              core_rst,
    output logic                              running,
    output logic [program_counter_length:0]   load_count,
    output logic                              load_err
`ifdef IMEM_PARITY_EN
    ,output logic                             parity_err
`endif
);

    localparam int ADDR_W = $clog2(IMEM_DEPTH);
    localparam logic [program_counter_length:0] LAST_IDX = (program_counter_length+1)'(IMEM_DEPTH-1);
`ifdef IMEM_PARITY_EN
    localparam int RAM_W = $bits(instruction_t) + 1;
`else
    localparam int RAM_W = $bits(instruction_t);
`endif

    fetch_state_t      state;
    logic              beat;
    logic [ADDR_W-1:0] rd_addr;
    logic [RAM_W-1:0]  wr_word;
    logic [RAM_W-1:0]  rd_word;
    instruction_t      rd_instr;

    assign load_ready = (state == IDLE) && !rst;
    assign beat       = load_valid && load_ready;
    // Control's next PC is meaningless while it sits in reset, so fetch from 0 until RUN.
    assign rd_addr    = (state == RUN) ? next_program_counter[ADDR_W-1:0] : '0;
    assign core_rst   = (state != RUN);
    assign running    = (state == RUN);

`ifdef IMEM_PARITY_EN
    logic parity_bad;
    assign wr_word    = {even_parity(load_data), load_data};
    assign rd_instr   = rd_word[$bits(instruction_t)-1:0];
    assign parity_bad = (state == RUN) && (^rd_word);
    assign instruction = ((state == RUN) && !parity_bad) ? rd_instr : NOP_INSTR;
`else
    assign wr_word     = load_data;
    assign rd_instr    = rd_word;
    assign instruction = (state == RUN) ? rd_instr : NOP_INSTR;
`endif

    imem_sdp_ram #(
        .WIDTH (RAM_W),
        .DEPTH (IMEM_DEPTH)
    ) u_imem (
        .clk   (clk),
        .we    (beat),
        .waddr (load_count[ADDR_W-1:0]),
        .wdata (wr_word),
        .raddr (rd_addr),
        .rdata (rd_word)
    );

    // A beat that fills the last slot without load_last closes the program and flags truncation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            load_count <= '0;
            load_err   <= 1'b0;
`ifdef IMEM_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (beat) begin
                        load_count <= load_count + 1'b1;
                        if (load_last) begin
                            state <= LOADED;
                        end else if (load_count == LAST_IDX) begin
                            state    <= LOADED;
                            load_err <= 1'b1;
                        end
                    end
                end
                LOADED: begin
                    if (clear) begin
                        state      <= IDLE;
                        load_count <= '0;
                        load_err   <= 1'b0;
                    end else if (start) begin
                        state <= PRIME;
                    end
                end
                PRIME: begin
                    state <= RUN;
                end
                RUN: begin
`ifdef IMEM_PARITY_EN
                    if (parity_bad) begin
                        state      <= FAULT;
                        parity_err <= 1'b1;
                    end else if (stop) begin
                        state <= LOADED;
                    end
`else
                    if (stop) begin
                        state <= LOADED;
                    end
`endif
                end
`ifdef IMEM_PARITY_EN
                FAULT: begin
                    if (clear) begin
                        state      <= IDLE;
                        load_count <= '0;
                        load_err   <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: randomized program words checked against an array model.
// Defining IMEM_PARITY_EN also exercises the parity fault path.
module tb_instruction_fetch;
    import instruction_fetch_pkg::*;

    localparam int DEPTH = 2**program_counter_length;

    logic                              clk;
    logic                              rst;
    logic                              load_valid;
    logic                              load_ready;
    instruction_t                      load_data;
    logic                              load_last;
    logic                              start;
    logic                              stop;
    logic                              clear;
    logic [program_counter_length-1:0] next_program_counter;
    instruction_t                      instruction;
    logic                              core_rst;
    logic                              running;
    logic [program_counter_length:0]   load_count;
    logic                              load_err;
`ifdef IMEM_PARITY_EN
    logic                              parity_err;
`endif

    int assert_count = 0;
    int fail_count   = 0;

    instruction_t model_mem [DEPTH];
    int           m_count;

    instruction_fetch u_dut (
        .clk                  (clk),
        .rst                  (rst),
        .load_valid           (load_valid),
        .load_ready           (load_ready),
        .load_data            (load_data),
        .load_last            (load_last),
        .start                (start),
        .stop                 (stop),
        .clear                (clear),
        .next_program_counter (next_program_counter),
        .instruction          (instruction),
        .core_rst             (core_rst),
        .running              (running),
        .load_count           (load_count),
        .load_err             (load_err)
`ifdef IMEM_PARITY_EN
        ,.parity_err          (parity_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pushes n host beats of random words; load_last on the final one when with_last is set.
    task automatic load_words(input int n, input bit with_last);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_data  = $urandom;
            load_last  = with_last && (i == n - 1);
            assert_count++;
            if (load_ready !== 1'b1) begin fail_count++; $display("[TB] FAIL load_ready_beat%0d: got %b expected 1", i, load_ready); end
            model_mem[m_count] = load_data;
            m_count++;
            step();
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    // start -> PRIME -> RUN; first RUN cycle must present word 0 regardless of next PC.
    task automatic start_program(input string tag);
        next_program_counter = pc_reg_t'($urandom_range(1, DEPTH - 1));
        start = 1'b1;
        step();
        start = 1'b0;
        assert_count++;
        if (core_rst !== 1'b1 || instruction !== NOP) begin fail_count++; $display("[TB] FAIL %s_prime: core_rst=%b instr=%h expected 1/%h", tag, core_rst, instruction, NOP); end
        step();
        assert_count++;
        if (core_rst !== 1'b0 || running !== 1'b1) begin fail_count++; $display("[TB] FAIL %s_run_entry: core_rst=%b running=%b expected 0/1", tag, core_rst, running); end
        assert_count++;
        if (instruction !== model_mem[0]) begin fail_count++; $display("[TB] FAIL %s_first_word: got %h expected %h", tag, instruction, model_mem[0]); end
    endtask

    task automatic fetch_check(input int pc, input string tag);
        next_program_counter = pc_reg_t'(pc);
        step();
        assert_count++;
        if (instruction !== model_mem[pc]) begin fail_count++; $display("[TB] FAIL %s_pc%0d: got %h expected %h", tag, pc, instruction, model_mem[pc]); end
    endtask

    task automatic test_reset();
        rst = 1'b1; load_valid = 1'b0; load_data = '0; load_last = 1'b0;
        start = 1'b0; stop = 1'b0; clear = 1'b0; next_program_counter = '0;
        step();
        step();
        assert_count++;
        if (instruction !== NOP || core_rst !== 1'b1 || running !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_outputs: instr=%h core_rst=%b running=%b expected %h/1/0", instruction, core_rst, running, NOP); end
        assert_count++;
        if (load_ready !== 1'b0 || load_count !== '0 || load_err !== 1'b0) begin fail_count++; $display("[TB] FAIL reset_load: ready=%b count=%0d err=%b expected 0/0/0", load_ready, load_count, load_err); end
        rst = 1'b0;
        m_count = 0;
        step();
        assert_count++;
        if (load_ready !== 1'b1) begin fail_count++; $display("[TB] FAIL idle_ready: got %b expected 1", load_ready); end
        start = 1'b1;
        step();
        start = 1'b0;
        assert_count++;
        if (core_rst !== 1'b1 || load_ready !== 1'b1) begin fail_count++; $display("[TB] FAIL idle_start_ignored: core_rst=%b ready=%b expected 1/1", core_rst, load_ready); end
    endtask

    task automatic test_load();
        load_words(3, 1'b1);
        assert_count++;
        if (load_count !== 5'(m_count)) begin fail_count++; $display("[TB] FAIL load3_count: got %0d expected %0d", load_count, m_count); end
        assert_count++;
        if (load_ready !== 1'b0 || load_err !== 1'b0 || core_rst !== 1'b1) begin fail_count++; $display("[TB] FAIL load3_loaded: ready=%b err=%b core_rst=%b expected 0/0/1", load_ready, load_err, core_rst); end
    endtask

    task automatic test_run();
        start_program("run");
        fetch_check(1, "run");
        fetch_check(2, "run");
        fetch_check(0, "run");
        for (int i = 0; i < 6; i++) fetch_check($urandom_range(0, 2), "run_rand");
        stop = 1'b1;
        step();
        stop = 1'b0;
        assert_count++;
        if (running !== 1'b0 || core_rst !== 1'b1 || instruction !== NOP) begin fail_count++; $display("[TB] FAIL run_stop: running=%b core_rst=%b instr=%h expected 0/1/%h", running, core_rst, instruction, NOP); end
    endtask

    task automatic test_overflow();
        clear = 1'b1;
        step();
        clear = 1'b0;
        m_count = 0;
        assert_count++;
        if (load_ready !== 1'b1 || load_count !== '0) begin fail_count++; $display("[TB] FAIL clear_idle: ready=%b count=%0d expected 1/0", load_ready, load_count); end
        load_words(DEPTH - 1, 1'b0);
        assert_count++;
        if (load_err !== 1'b0 || load_ready !== 1'b1) begin fail_count++; $display("[TB] FAIL overflow_premature: err=%b ready=%b expected 0/1", load_err, load_ready); end
        load_words(1, 1'b0);
        assert_count++;
        if (load_err !== 1'b1 || load_count !== 5'(DEPTH) || load_ready !== 1'b0) begin fail_count++; $display("[TB] FAIL overflow_state: err=%b count=%0d ready=%b expected 1/%0d/0", load_err, load_count, load_ready, DEPTH); end
        load_valid = 1'b1;
        load_data  = $urandom;
        step();
        load_valid = 1'b0;
        assert_count++;
        if (load_count !== 5'(DEPTH)) begin fail_count++; $display("[TB] FAIL loaded_ignores_valid: count=%0d expected %0d", load_count, DEPTH); end
        start_program("full");
        for (int i = 0; i < 20; i++) fetch_check($urandom_range(0, DEPTH - 1), "full_rand");
    endtask

    task automatic test_stop_start();
        stop  = 1'b1;
        start = 1'b1;
        step();
        stop  = 1'b0;
        start = 1'b0;
        assert_count++;
        if (running !== 1'b0 || core_rst !== 1'b1 || instruction !== NOP) begin fail_count++; $display("[TB] FAIL stop_beats_start: running=%b core_rst=%b instr=%h expected 0/1/%h", running, core_rst, instruction, NOP); end
        step();
        assert_count++;
        if (core_rst !== 1'b1 || load_count !== 5'(DEPTH)) begin fail_count++; $display("[TB] FAIL stop_holds: core_rst=%b count=%0d expected 1/%0d", core_rst, load_count, DEPTH); end
        start_program("rerun");
        fetch_check(DEPTH - 1, "rerun");
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    task automatic test_reset_mid_load();
        clear = 1'b1;
        step();
        clear = 1'b0;
        m_count = 0;
        load_words(1, 1'b0);
        rst        = 1'b1;
        load_valid = 1'b1;
        load_data  = $urandom;
        step();
        assert_count++;
        if (load_count !== '0 || load_ready !== 1'b0) begin fail_count++; $display("[TB] FAIL rst_mid_load: count=%0d ready=%b expected 0/0", load_count, load_ready); end
        rst        = 1'b0;
        load_valid = 1'b0;
        m_count    = 0;
        step();
        assert_count++;
        if (load_ready !== 1'b1 || load_count !== '0) begin fail_count++; $display("[TB] FAIL rst_release: ready=%b count=%0d expected 1/0", load_ready, load_count); end
        load_words(2, 1'b1);
        assert_count++;
        if (load_count !== 5'd2 || load_ready !== 1'b0) begin fail_count++; $display("[TB] FAIL reload_count: count=%0d ready=%b expected 2/0", load_count, load_ready); end
        start_program("reload");
        fetch_check(1, "reload");
        rst = 1'b1;
        step();
        assert_count++;
        if (running !== 1'b0 || core_rst !== 1'b1 || instruction !== NOP || load_count !== '0) begin fail_count++; $display("[TB] FAIL rst_mid_run: running=%b core_rst=%b instr=%h count=%0d expected 0/1/%h/0", running, core_rst, instruction, load_count, NOP); end
        rst = 1'b0;
        m_count = 0;
        step();
    endtask

`ifdef IMEM_PARITY_EN
    task automatic test_parity();
        load_words(3, 1'b1);
        start_program("parity");
        fetch_check(2, "parity_clean");
        u_dut.u_imem.mem[1] = u_dut.u_imem.mem[1] ^ 33'd1;
        next_program_counter = 4'd1;
        step();
        next_program_counter = 4'd0;
        step();
        assert_count++;
        if (parity_err !== 1'b1 || core_rst !== 1'b1 || running !== 1'b0 || instruction !== NOP) begin fail_count++; $display("[TB] FAIL parity_fault: perr=%b core_rst=%b running=%b instr=%h expected 1/1/0/%h", parity_err, core_rst, running, instruction, NOP); end
        clear = 1'b1;
        step();
        clear = 1'b0;
        assert_count++;
        if (load_ready !== 1'b1 || load_count !== '0) begin fail_count++; $display("[TB] FAIL parity_clear: ready=%b count=%0d expected 1/0", load_ready, load_count); end
    endtask
`endif

    initial begin
        test_reset();
        test_load();
        test_run();
        test_overflow();
        test_stop_start();
        test_reset_mid_load();
`ifdef IMEM_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
